// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win the register-file port, MDU results queue in a FIFO.
// Define WB_PENDING_EN to add pending_mask, a per-register "write still queued" flag vector.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [31:0]                   alu_data,
  input  logic                          mdu_valid,
  output logic                          mdu_ready,
  input  logic [4:0]                    mdu_rd,
  input  logic [31:0]                   mdu_data,
  output logic [4:0]                    rd,
  output logic                          write_enable,
  output logic [31:0]                   write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_PENDING_EN
  ,
  output logic [31:0]                   pending_mask
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;

  // Storage carries no reset: entries are only read while count_q covers them.
  logic [4:0]      mem_rd_q   [FIFO_DEPTH];
  logic [31:0]     mem_data_q [FIFO_DEPTH];

  logic alu_live;
  logic pop;
  logic push;

  assign mdu_ready    = (count_q != FullCount);
  assign rd           = rd_q;
  assign write_enable = we_q;
  assign write_data   = wdata_q;
  assign fifo_count   = count_q;

  always_comb begin
    alu_live = alu_valid && (alu_rd != 5'd0);
    pop      = !alu_live && (count_q != '0);
    // x0 results are acknowledged but never stored.
    push     = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    if (alu_live) begin
      we_d    = 1'b1;
      rd_d    = alu_rd;
      wdata_d = alu_data;
    end else if (pop) begin
      we_d    = 1'b1;
      rd_d    = mem_rd_q[rptr_q];
      wdata_d = mem_data_q[rptr_q];
      rptr_d  = rptr_q + 1'b1;
    end

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end

    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wptr_q]   <= mdu_rd;
      mem_data_q[wptr_q] <= mdu_data;
    end
  end

`ifdef WB_PENDING_EN
  // Derived from the occupied window of the ring, so it tracks push/pop on the same edge.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (CntW'(i) < count_q) begin
        pending_mask[mem_rd_q[rptr_q + PtrW'(i)]] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter with a queue-based reference model and scoreboard.
// Define WB_PENDING_EN to also check pending_mask.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic [4:0]  rd;
  logic        write_enable;
  logic [31:0] write_data;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_PENDING_EN
  logic [31:0] pending_mask;
`endif

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .rd           (rd),
    .write_enable (write_enable),
    .write_data   (write_data),
    .fifo_count   (fifo_count)
`ifdef WB_PENDING_EN
    ,
    .pending_mask (pending_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cnt;
    logic [31:0] pmask;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        fifo_m[$];
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model's prediction for the following edge is queued.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    exp_t e;
    ent_t ent;
    bit   ready;
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    mdu_valid = mv;
    mdu_rd    = mr;
    mdu_data  = md;
    ready = (fifo_m.size() != DEPTH);
    e.we = 1'b0;
    if (av && ar != 5'd0) begin
      e.we      = 1'b1;
      last_rd   = ar;
      last_data = ad;
    end else if (fifo_m.size() > 0) begin
      ent       = fifo_m.pop_front();
      e.we      = 1'b1;
      last_rd   = ent.rd;
      last_data = ent.data;
    end
    if (mv && ready && mr != 5'd0) begin
      ent.rd   = mr;
      ent.data = md;
      fifo_m.push_back(ent);
    end
    e.rd    = last_rd;
    e.data  = last_data;
    e.cnt   = fifo_m.size();
    e.pmask = '0;
    foreach (fifo_m[i]) e.pmask[fifo_m[i].rd] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic reset_dut(input bit mid_op);
    @(posedge clk);
    #2;
    alu_valid = 1'b0;
    mdu_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", {31'd0, mdu_ready}, 32'd1);
`ifdef WB_PENDING_EN
    check("rst_pmask", pending_mask, 32'd0);
`endif
    if (mid_op) exp_q.delete();
    fifo_m.delete();
    last_rd   = '0;
    last_data = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: compares each cycle's registered outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_enable", {31'd0, write_enable}, {31'd0, e.we});
        check("rd", {27'd0, rd}, {27'd0, e.rd});
        check("write_data", write_data, e.data);
        check("fifo_count", 32'(fifo_count), 32'(e.cnt));
        check("mdu_ready", {31'd0, mdu_ready}, {31'd0, (e.cnt != DEPTH)});
        if (write_enable && rd == 5'd0) check("we_on_x0", 32'd1, 32'd0);
`ifdef WB_PENDING_EN
        check("pending_mask", pending_mask, e.pmask);
`endif
      end
    end
  end

  initial begin
    int k;
    #2;
    rst_n = 1'b0;
    #1;
    reset_dut(1'b0);

    // ALU only
    step(1'b1, 5'd4, 32'd40, 1'b0, 5'd0, 32'd0);
    idle(1);

    // x0 filter on both sources
    step(1'b1, 5'd0, 32'd100, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd55);
    idle(2);

    // Priority: MDU waits behind three ALU writes
    step(1'b1, 5'd5, 32'd1, 1'b1, 5'd10, 32'd100);
    step(1'b1, 5'd5, 32'd2, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd5, 32'd3, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Full and wrap: offer x1..x6, ALU busy first
    k = 1;
    for (int c = 0; c < 20 && k <= 6; c++) begin
      bit rdy;
      rdy = (fifo_m.size() != DEPTH);
      step((c < 7), 5'd9, 32'(c), 1'b1, 5'(k), 32'(k * 11));
      if (rdy) k++;
    end
    idle(4);

    // Pending mask on x7
    step(1'b1, 5'd2, 32'd20, 1'b1, 5'd7, 32'd77);
    step(1'b1, 5'd2, 32'd21, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Reset mid-operation with three entries queued
    step(1'b1, 5'd3, 32'd0, 1'b1, 5'd11, 32'd111);
    step(1'b1, 5'd3, 32'd0, 1'b1, 5'd12, 32'd112);
    step(1'b1, 5'd3, 32'd0, 1'b1, 5'd13, 32'd113);
    reset_dut(1'b1);
    idle(4);
    step(1'b1, 5'd6, 32'd66, 1'b0, 5'd0, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [4:0] ar;
      logic [4:0] mr;
      ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(($urandom_range(0, 99) < 55), ar, $urandom(),
           ($urandom_range(0, 99) < 60), mr, $urandom());
    end
    idle(DEPTH + 3);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered MDU results (power of two, 2..16).
REQ-003 SHALL have ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result present this cycle; always accepted
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- mdu_valid  input  1  multi-cycle unit result offered
- mdu_ready  output  1  buffer can accept MDU result
- mdu_rd  input  5  MDU destination register
- mdu_data  input  32  MDU result
- rd  output  5  register file write address
- write_enable  output  1  register file write strobe
- write_data  output  32  register file write data
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries

Function
REQ-004 SHALL register rd/write_enable/write_data: selection made in cycle N appears in cycle N+1 and is written by the register file on the next rising edge.
REQ-005 SHALL treat an ALU request with alu_valid=1 and alu_rd!=0 as a live ALU write.
REQ-006 SHALL give a live ALU write strict priority: it is issued and the FIFO does not pop that cycle.
REQ-007 SHALL pop and issue the FIFO head when there is no live ALU write and fifo_count>0.
REQ-008 SHALL deassert write_enable, and hold rd and write_data at their previous values, when nothing is issued.
REQ-009 SHALL never assert write_enable with rd=0.
REQ-010 SHALL accept an MDU handshake when mdu_valid and mdu_ready are both 1 on a rising edge.
REQ-011 SHALL discard an accepted MDU result with mdu_rd=0 without storing it.
REQ-012 SHALL drive mdu_ready = (fifo_count != FIFO_DEPTH), registered-state based only. When the FIFO is full, it SHALL refuse a push even if a pop occurs in the same cycle.
REQ-013 SHALL allow a simultaneous push and pop when not full; fifo_count is then unchanged.
REQ-014 SHALL implement the FIFO as a circular buffer. Read and write pointers wrap modulo FIFO_DEPTH, and issue order equals accept order.
REQ-015 SHALL NOT let an ALU result bypass into the FIFO. An ALU request with alu_rd=0 is dropped, and the FIFO may pop that cycle.
REQ-016 SHALL bound FIFO wait under continuous ALU traffic by external issue logic only. The block imposes no starvation guard.

Reset
REQ-017 SHALL, on rst_n low, asynchronously clear write_enable=0, rd=0, write_data=0, fifo_count=0, both pointers=0, and set mdu_ready=1.
REQ-018 SHALL lose all buffered entries on reset mid-operation; no write issues from pre-reset contents.
REQ-019 SHALL issue nothing on the first edge after rst_n deasserts unless alu_valid is high in that cycle.

Configuration
REQ-020 SHALL, with WB_PENDING_EN defined, add output pending_mask[31:0].
- Bit r is 1 while any FIFO entry targets register r.
- The mask is updated in the same edge as push/pop and is cleared by reset.
REQ-021 SHALL, without WB_PENDING_EN, omit pending_mask and its logic entirely; all other behaviour is identical.

Verification
REQ-022 ALU only: alu_valid=1, alu_rd=4, alu_data=40 at cycle 0 -> cycle 1 write_enable=1, rd=4, write_data=40.
REQ-023 x0 filter: alu_rd=0, alu_data=100; then accept mdu_rd=0 -> write_enable stays 0 and fifo_count stays 0.
REQ-024 Priority: push MDU (rd=10, data=100) while ALU writes rd=5 for 3 cycles -> ALU writes x5 ×3. MDU x10=100 issues in the first cycle after alu_valid drops.
REQ-025 Full/wrap: push 6 MDU results (rd=1..6) with ALU busy.
- mdu_ready falls after 4 accepts and fifo_count=4.
- After ALU stops, writes issue in order x1..x4; then x5 and x6 are accepted, exercising pointer wrap.
REQ-026 Reset mid-operation: fifo_count=3, then rst_n pulsed low asynchronously between edges -> outputs zero immediately, fifo_count=0, no stale writes afterwards.
REQ-027 WB_PENDING_EN: queue rd=7 -> pending_mask=0x00000080 until the x7 write issues, then 0.
